// File: rtl/flash_fill_arbiter.sv
// flash_fill_arbiter: shares one quad-I/O flash line reader among NREQ refill requesters.
// Optional FFA_ROUND_ROBIN_EN selects rotating priority; default is fixed lowest-index priority.
module flash_fill_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = 24,
    parameter int LINE_SIZE = 128
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        rsp_done,
    output logic [LINE_SIZE-1:0]   rsp_line,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic [ADDR_W-1:0]      fr_addr,
    output logic                   fr_rd,
    input  logic                   fr_done,
    input  logic [LINE_SIZE-1:0]   fr_line
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      win;
    logic [ADDR_W-1:0] sel_addr;
    logic            grant_en;
    logic            line_en;
    logic            unused_offset;

`ifdef FFA_ROUND_ROBIN_EN
    logic [1:0]      ptr;
    logic [NREQ-1:0] rot;
    int              sum;

    // Rotate so the pointer slot sits at bit 0, then map back to a real index.
    always_comb begin
        win = '0;
        sum = 0;
        rot = NREQ'({req_valid, req_valid} >> ptr);
        for (int o = NREQ - 1; o >= 0; o--) begin
            if (rot[o]) begin
                sum = int'(ptr) + o;
                if (sum >= NREQ) sum = sum - NREQ;
                win = 2'(sum);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ptr <= '0;
        end else if (grant_en) begin
            ptr <= (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) win = 2'(i);
        end
    end
`endif

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == 2'(k)) sel_addr = req_addr[k*ADDR_W +: ADDR_W];
        end
    end

    assign unused_offset = ^sel_addr[3:0];

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        line_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_en  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (fr_done) begin
                    line_en   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign fr_rd = (state == ISSUE);
    assign busy  = (state != IDLE);

    // Coalesce every live request on the latched line; the grantee always completes.
    always_comb begin
        rsp_done = '0;
        if (state == RESP) begin
            for (int k = 0; k < NREQ; k++) begin
                rsp_done[k] = (grant_id == 2'(k)) ||
                    (req_valid[k] &&
                     (req_addr[k*ADDR_W+4 +: ADDR_W-4] == fr_addr[ADDR_W-1:4]));
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            grant_id <= '0;
            fr_addr  <= '0;
            rsp_line <= '0;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                grant_id <= win;
                fr_addr  <= {sel_addr[ADDR_W-1:4], 4'd0};
            end
            if (line_en) rsp_line <= fr_line;
        end
    end

endmodule

// File: doc/flash_fill_arbiter.md
Name: flash_fill_arbiter

Overview:
- Shares one quad-I/O flash line reader between NREQ line-refill requesters, e.g. the instruction-cache miss path, a data-read port and a prefetcher.
- Latches one request at a time and issues a single-cycle rd with the line-aligned address.
- Waits for done, captures the 128-bit line and returns it with a one-cycle completion pulse.
- Completes in the same cycle every other pending request for the identical line.

Parameters:
- NREQ, 2, number of requesters (2..4).
- ADDR_W, 24, flash byte-address width.
- LINE_SIZE, 128, line width in bits; line is 16 bytes, offset bits [3:0].

Ports:
- HCLK  input  1  clock.
- HRESETn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester level request; held until that requester's rsp_done.
- req_addr  input  NREQ*ADDR_W  packed byte addresses; slot i is [i*ADDR_W +: ADDR_W]; stable while req_valid[i]=1.
- rsp_done  output  NREQ  one-cycle completion pulse per requester.
- rsp_line  output  LINE_SIZE  registered line data; valid whenever any rsp_done bit is 1.
- grant_id  output  2  index of the requester currently being served.
- busy  output  1  high in every state except IDLE.
- fr_addr  output  ADDR_W  to reader: {latched_addr[ADDR_W-1:4], 4'd0}.
- fr_rd  output  1  to reader: one-cycle start pulse.
- fr_done  input  1  from reader: one-cycle line-ready pulse.
- fr_line  input  LINE_SIZE  from reader: line data, valid when fr_done=1.

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous and active-low.
- Reset values: state=IDLE, fr_rd=0, rsp_done=0, busy=0, grant_id=0, fr_addr=0, rsp_line=0, round-robin pointer=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, select a winner and latch its index (grant_id) and line address (fr_addr); go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - fr_rd=1 for exactly this cycle; go to WAIT.
- WAIT:
  - fr_rd=0; fr_addr held.
  - On fr_done=1, register fr_line into rsp_line and go to RESP.
  - No timeout; stays in WAIT indefinitely.
- RESP:
  - rsp_done[k]=1 for every k where req_valid[k]=1 and req_addr[k][ADDR_W-1:4] equals the latched line address. The granted index is always included.
  - Go to IDLE.
- Latency:
  - Winner sampled at edge 0; fr_rd high in cycle 1.
  - fr_done seen in cycle N; rsp_done high in cycle N+1.
  - Next grant is sampled at the edge after the RESP cycle (at the earliest, the requests of cycle N+2).
- Requester rule: drop req_valid, or present a new address, on the edge ending the rsp_done cycle. A request still asserted in IDLE is treated as new.
- Winner selection: fixed priority, lowest index wins (see Optional Feature).
- Boundary conditions:
  - A req_valid that drops before rsp_done is a protocol violation. The transaction still completes, and rsp_done fires for the granted index regardless.
  - fr_done in IDLE, ISSUE or RESP is ignored.
  - Requests arriving while busy are held off by the requester and are not queued internally.
  - Two requesters on the same line in IDLE: one fr_rd only, both rsp_done bits set in one RESP cycle.
  - Reset asserted mid-transaction: immediate return to all reset values with no rsp_done pulse. The reader shares HRESETn and aborts too.
  - Address offset bits [3:0] never reach fr_addr.

Optional Feature:
- Macro: FFA_ROUND_ROBIN_EN.
- Defined: rotating priority. After a grant to index g, the pointer becomes (g+1) mod NREQ, and the search starts at the pointer, wrapping. Coalesced extra completions do not move the pointer.
- Undefined: fixed priority, index 0 highest; the pointer is absent.

Test Plan:
- Single request: req_valid=01, req_addr[0]=0x01234C → fr_rd pulse in cycle 1 with fr_addr=0x012340. Reader returns fr_done + fr_line=0x00112233_44556677_8899AABB_CCDDEEFF → rsp_done=01 next cycle, rsp_line equal to fr_line, busy=0 after.
- Simultaneous requests: req_valid=11, addr0=0x000100, addr1=0x000200, fixed priority → two fr_rd pulses, 0x000100 first then 0x000200. rsp_done=01 then 10; grant_id 0 then 1.
- Coalescing: req_valid=11, both addresses in line 0x0004A0 (0x0004A4, 0x0004AC) → exactly one fr_rd; a single RESP cycle with rsp_done=11.
- Round-robin (FFA_ROUND_ROBIN_EN), NREQ=2: both requesters re-request every time on distinct lines for 4 grants → grant_id sequence 0,1,0,1. Without the macro: 0,0,0,0 while req_valid[0] persists.
- Reset in WAIT: HRESETn low 2 cycles after fr_rd → fr_rd=0, rsp_done=00, busy=0 immediately. A later fr_done is ignored. A fresh request afterwards completes normally.
- Stray fr_done in IDLE with no requests → no rsp_done, state stays IDLE, rsp_line unchanged.
